// File: rtl/tl_arbiter_if.sv
// TileLink-UL bundle seen by tl_arbiter: NUM_MASTERS flattened upstream ports (master i at slice i)
// plus the single shared downstream port.
interface tl_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int XLEN        = 32,
   parameter int SID_WIDTH   = 2
);
   localparam int NM  = NUM_MASTERS;
   localparam int MSK = XLEN / 8;

   logic [NM-1:0]           m_a_valid;
   logic [NM-1:0]           m_a_ready;
   logic [3*NM-1:0]         m_a_opcode;
   logic [3*NM-1:0]         m_a_param;
   logic [3*NM-1:0]         m_a_size;
   logic [SID_WIDTH*NM-1:0] m_a_source;
   logic [XLEN*NM-1:0]      m_a_address;
   logic [XLEN*NM-1:0]      m_a_data;
   logic [MSK*NM-1:0]       m_a_mask;

   logic [NM-1:0]           m_d_valid;
   logic [NM-1:0]           m_d_ready;
   logic [3*NM-1:0]         m_d_opcode;
   logic [2*NM-1:0]         m_d_param;
   logic [3*NM-1:0]         m_d_size;
   logic [SID_WIDTH*NM-1:0] m_d_source;
   logic [XLEN*NM-1:0]      m_d_data;
   logic [NM-1:0]           m_d_corrupt;
   logic [NM-1:0]           m_d_denied;

   logic                    tl_a_valid;
   logic                    tl_a_ready;
   logic [2:0]              tl_a_opcode;
   logic [2:0]              tl_a_param;
   logic [2:0]              tl_a_size;
   logic [SID_WIDTH-1:0]    tl_a_source;
   logic [XLEN-1:0]         tl_a_address;
   logic [XLEN-1:0]         tl_a_data;
   logic [MSK-1:0]          tl_a_mask;

   logic                    tl_d_valid;
   logic                    tl_d_ready;
   logic [2:0]              tl_d_opcode;
   logic [1:0]              tl_d_param;
   logic [2:0]              tl_d_size;
   logic [SID_WIDTH-1:0]    tl_d_source;
   logic [XLEN-1:0]         tl_d_data;
   logic                    tl_d_corrupt;
   logic                    tl_d_denied;

   // Arbiter view.
   modport slave (
      input  m_a_valid, m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address, m_a_data, m_a_mask,
      output m_a_ready,
      output m_d_valid, m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_data, m_d_corrupt, m_d_denied,
      input  m_d_ready,
      output tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address, tl_a_data,
             tl_a_mask,
      input  tl_a_ready,
      input  tl_d_valid, tl_d_opcode, tl_d_param, tl_d_size, tl_d_source, tl_d_data, tl_d_corrupt,
             tl_d_denied,
      output tl_d_ready
   );

   // Requesters plus downstream device view.
   modport master (
      output m_a_valid, m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address, m_a_data, m_a_mask,
      input  m_a_ready,
      input  m_d_valid, m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_data, m_d_corrupt, m_d_denied,
      output m_d_ready,
      input  tl_a_valid, tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address, tl_a_data,
             tl_a_mask,
      output tl_a_ready,
      output tl_d_valid, tl_d_opcode, tl_d_param, tl_d_size, tl_d_source, tl_d_data, tl_d_corrupt,
             tl_d_denied,
      input  tl_d_ready
   );
endinterface

// File: rtl/tl_arbiter.sv
// Round-robin TileLink-UL arbiter: NUM_MASTERS requesters share one downstream port through a
// registered A stage; sources are remapped to tags and D beats are routed back via a tag table.
module tl_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int XLEN        = 32,
   parameter int SID_WIDTH   = 2
) (
   input  logic        clk,
   input  logic        reset,
   tl_arbiter_if.slave bus,
   output logic        err_unexpected
);
   localparam int NM    = NUM_MASTERS;
   localparam int MIW   = $clog2(NM);
   localparam int NTAGS = 1 << SID_WIDTH;
   localparam int MSK   = XLEN / 8;

   logic [MIW-1:0]       rr_ptr;
   logic [NTAGS-1:0]     tag_busy;
   logic [MIW-1:0]       tag_master [NTAGS];
   logic [SID_WIDTH-1:0] tag_src    [NTAGS];

   logic                 a_valid;
   logic [2:0]           a_opcode, a_param, a_size;
   logic [SID_WIDTH-1:0] a_source;
   logic [XLEN-1:0]      a_address, a_data;
   logic [MSK-1:0]       a_mask;

   logic [MIW-1:0]       winner;
   logic                 any_req;
   logic [SID_WIDTH-1:0] free_tag;
   logic                 tag_avail;
   logic                 grant;

   logic [SID_WIDTH-1:0] d_tag;
   logic [MIW-1:0]       d_owner;
   logic                 d_hit;

   // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      for (int k = 0; k < NM; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NM;
         if (!any_req && bus.m_a_valid[idx]) begin
            any_req = 1'b1;
            winner  = MIW'(idx);
         end
      end

      free_tag  = '0;
      tag_avail = 1'b0;
      for (int t = 0; t < NTAGS; t++) begin
         if (!tag_avail && !tag_busy[t]) begin
            tag_avail = 1'b1;
            free_tag  = SID_WIDTH'(t);
         end
      end

      // The stage may reload in the same cycle it hands its beat downstream.
      grant = !reset && any_req && tag_avail && (!a_valid || bus.tl_a_ready);
      bus.m_a_ready = '0;
      if (grant) bus.m_a_ready[winner] = 1'b1;
   end

   assign d_tag   = bus.tl_d_source;
   assign d_owner = tag_master[d_tag];
   assign d_hit   = !reset && tag_busy[d_tag];

   always_comb begin
      bus.m_d_valid = '0;
      if (d_hit) bus.m_d_valid[d_owner] = bus.tl_d_valid;
      // Beats on unallocated tags are swallowed so they cannot stall the downstream port.
      bus.tl_d_ready = d_hit ? bus.m_d_ready[d_owner] : (bus.tl_d_valid && !reset);
      err_unexpected = bus.tl_d_valid && !d_hit && !reset;
   end

   assign bus.m_d_opcode  = {NM{bus.tl_d_opcode}};
   assign bus.m_d_param   = {NM{bus.tl_d_param}};
   assign bus.m_d_size    = {NM{bus.tl_d_size}};
   assign bus.m_d_source  = {NM{tag_src[d_tag]}};
   assign bus.m_d_data    = {NM{bus.tl_d_data}};
   assign bus.m_d_corrupt = {NM{bus.tl_d_corrupt}};
   assign bus.m_d_denied  = {NM{bus.tl_d_denied}};

   assign bus.tl_a_valid   = a_valid;
   assign bus.tl_a_opcode  = a_opcode;
   assign bus.tl_a_param   = a_param;
   assign bus.tl_a_size    = a_size;
   assign bus.tl_a_source  = a_source;
   assign bus.tl_a_address = a_address;
   assign bus.tl_a_data    = a_data;
   assign bus.tl_a_mask    = a_mask;

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr    <= '0;
         tag_busy  <= '0;
         a_valid   <= 1'b0;
         a_opcode  <= '0;
         a_param   <= '0;
         a_size    <= '0;
         a_source  <= '0;
         a_address <= '0;
         a_data    <= '0;
         a_mask    <= '0;
      end else begin
         if (bus.tl_d_valid && bus.tl_d_ready && d_hit) tag_busy[d_tag] <= 1'b0;
         if (a_valid && bus.tl_a_ready) a_valid <= 1'b0;
         if (grant) begin
            rr_ptr             <= (int'(winner) == NM - 1) ? '0 : winner + 1'b1;
            tag_busy[free_tag] <= 1'b1;
            a_valid            <= 1'b1;
            a_opcode           <= bus.m_a_opcode[winner*3 +: 3];
            a_param            <= bus.m_a_param[winner*3 +: 3];
            a_size             <= bus.m_a_size[winner*3 +: 3];
            a_source           <= free_tag;
            a_address          <= bus.m_a_address[winner*XLEN +: XLEN];
            a_data             <= bus.m_a_data[winner*XLEN +: XLEN];
            a_mask             <= bus.m_a_mask[winner*MSK +: MSK];
         end
      end
   end

   // NOTE: tag payload is only read while its busy bit is set, so this storage needs no reset.
   always_ff @(posedge clk) begin
      if (grant) begin
         tag_master[free_tag] <= winner;
         tag_src[free_tag]    <= bus.m_a_source[winner*SID_WIDTH +: SID_WIDTH];
      end
   end
endmodule

// File: tb/tb_tl_arbiter.sv
// Self-checking bench for tl_arbiter: directed cycle table, stall/reset sequences, then random
// traffic against a queue-based reference model.
module tb_tl_arbiter;
   localparam int NM    = 2;
   localparam int XLEN  = 32;
   localparam int SID   = 2;
   localparam int NTAGS = 4;
   localparam int MSK   = XLEN / 8;

   logic clk = 1'b0;
   logic reset;
   logic err_unexpected;

   tl_arbiter_if #(.NUM_MASTERS(NM), .XLEN(XLEN), .SID_WIDTH(SID)) bus ();

   tl_arbiter #(.NUM_MASTERS(NM), .XLEN(XLEN), .SID_WIDTH(SID)) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .err_unexpected (err_unexpected)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]      op, param, size;
      logic [SID-1:0]  src;
      logic [XLEN-1:0] addr, data;
      logic [MSK-1:0]  mask;
   } req_t;

   task automatic drive_req(input int i, input req_t r);
      bus.m_a_opcode[i*3 +: 3]      = r.op;
      bus.m_a_param[i*3 +: 3]       = r.param;
      bus.m_a_size[i*3 +: 3]        = r.size;
      bus.m_a_source[i*SID +: SID]  = r.src;
      bus.m_a_address[i*XLEN +: XLEN] = r.addr;
      bus.m_a_data[i*XLEN +: XLEN]  = r.data;
      bus.m_a_mask[i*MSK +: MSK]    = r.mask;
   endtask

   function automatic req_t get_req(input logic [XLEN-1:0] addr, input logic [SID-1:0] src);
      req_t r;
      r.op = 3'd4; r.param = 3'd0; r.size = 3'd2; r.src = src;
      r.addr = addr; r.data = '0; r.mask = '1;
      return r;
   endfunction

   task automatic drive_d(input logic v, input logic [SID-1:0] src, input logic [XLEN-1:0] data,
                          input logic corrupt, input logic denied);
      bus.tl_d_valid   = v;
      bus.tl_d_opcode  = 3'd1;
      bus.tl_d_param   = 2'd0;
      bus.tl_d_size    = 3'd2;
      bus.tl_d_source  = src;
      bus.tl_d_data    = data;
      bus.tl_d_corrupt = corrupt;
      bus.tl_d_denied  = denied;
   endtask

   task automatic idle();
      bus.m_a_valid = '0;
      bus.m_d_ready = '0;
      bus.tl_a_ready = 1'b0;
      drive_d(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      idle();
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   // Directed per-cycle vectors; masters 0/1 present Get 0x100 src 1 / Get 0x200 src 2.
   typedef struct {
      logic [NM-1:0] mv;    logic ar;   logic dv;   logic [SID-1:0] dsrc; logic [NM-1:0] dr;
      logic [NM-1:0] e_mar; logic e_av; logic [SID-1:0] e_asrc; logic [XLEN-1:0] e_addr;
      logic [NM-1:0] e_dv;  logic e_dr; logic e_err; logic [SID-1:0] e_dsrc;
   } vec_t;

   function automatic vec_t mk(input logic [NM-1:0] mv, input logic ar, input logic dv,
                               input logic [SID-1:0] dsrc, input logic [NM-1:0] dr,
                               input logic [NM-1:0] e_mar, input logic e_av,
                               input logic [SID-1:0] e_asrc, input logic [XLEN-1:0] e_addr,
                               input logic [NM-1:0] e_dv, input logic e_dr, input logic e_err,
                               input logic [SID-1:0] e_dsrc);
      vec_t v;
      v.mv = mv; v.ar = ar; v.dv = dv; v.dsrc = dsrc; v.dr = dr;
      v.e_mar = e_mar; v.e_av = e_av; v.e_asrc = e_asrc; v.e_addr = e_addr;
      v.e_dv = e_dv; v.e_dr = e_dr; v.e_err = e_err; v.e_dsrc = e_dsrc;
      return v;
   endfunction

   vec_t vt[23];

   // Reference model state
   req_t pend[NM];
   bit   pend_v[NM];
   typedef struct { req_t r; int tag; } out_t;
   out_t stage_q[$];
   int   down_q[$];
   bit   tbusy[NTAGS];
   int   towner[NTAGS];
   logic [SID-1:0] tsrc[NTAGS];
   int   ptr;

   initial begin
      req_t put_r, m0_req, m1_req;
      int   own;
      m0_req = get_req(32'h100, 2'd1);
      m1_req = get_req(32'h200, 2'd2);

      //        mv   ar dv ds dr     mar  av as addr     dv   dr er dsrc
      vt[0]  = mk(2'b00,0,0,0,2'b00, 2'b00,0,0,32'h0,   2'b00,0,0,0);
      vt[1]  = mk(2'b01,1,0,0,2'b00, 2'b01,0,0,32'h0,   2'b00,0,0,0);
      vt[2]  = mk(2'b00,1,0,0,2'b00, 2'b00,1,0,32'h100, 2'b00,0,0,0);
      vt[3]  = mk(2'b00,1,1,0,2'b01, 2'b00,0,0,32'h0,   2'b01,1,0,1);
      vt[4]  = mk(2'b11,1,0,0,2'b00, 2'b10,0,0,32'h0,   2'b00,0,0,0);
      vt[5]  = mk(2'b11,1,0,0,2'b00, 2'b01,1,0,32'h200, 2'b00,0,0,0);
      vt[6]  = mk(2'b11,1,0,0,2'b00, 2'b10,1,1,32'h100, 2'b00,0,0,0);
      vt[7]  = mk(2'b11,1,0,0,2'b00, 2'b01,1,2,32'h200, 2'b00,0,0,0);
      vt[8]  = mk(2'b11,1,0,0,2'b00, 2'b00,1,3,32'h100, 2'b00,0,0,0);
      vt[9]  = mk(2'b11,1,0,0,2'b00, 2'b00,0,0,32'h0,   2'b00,0,0,0);
      vt[10] = mk(2'b11,1,1,2,2'b10, 2'b00,0,0,32'h0,   2'b10,1,0,2);
      vt[11] = mk(2'b11,1,0,0,2'b00, 2'b10,0,0,32'h0,   2'b00,0,0,0);
      vt[12] = mk(2'b00,0,0,0,2'b00, 2'b00,1,2,32'h200, 2'b00,0,0,0);
      vt[13] = mk(2'b01,0,0,0,2'b00, 2'b00,1,2,32'h200, 2'b00,0,0,0);
      vt[14] = mk(2'b00,1,0,0,2'b00, 2'b00,1,2,32'h200, 2'b00,0,0,0);
      vt[15] = mk(2'b00,1,1,1,2'b01, 2'b00,0,0,32'h0,   2'b01,1,0,1);
      vt[16] = mk(2'b00,1,1,0,2'b00, 2'b00,0,0,32'h0,   2'b10,0,0,2);
      vt[17] = mk(2'b00,1,1,0,2'b10, 2'b00,0,0,32'h0,   2'b10,1,0,2);
      vt[18] = mk(2'b00,1,1,0,2'b00, 2'b00,0,0,32'h0,   2'b00,1,1,0);
      vt[19] = mk(2'b00,1,1,3,2'b11, 2'b00,0,0,32'h0,   2'b01,1,0,1);
      vt[20] = mk(2'b00,1,1,2,2'b10, 2'b00,0,0,32'h0,   2'b10,1,0,2);
      vt[21] = mk(2'b00,1,1,3,2'b00, 2'b00,0,0,32'h0,   2'b00,1,1,0);
      vt[22] = mk(2'b00,0,0,0,2'b00, 2'b00,0,0,32'h0,   2'b00,0,0,0);

      reset = 1'b1;
      idle();
      drive_req(0, m0_req);
      drive_req(1, m1_req);
      apply_reset();

      for (int r = 0; r < 23; r++) begin
         bus.m_a_valid  = vt[r].mv;
         bus.tl_a_ready = vt[r].ar;
         bus.m_d_ready  = vt[r].dr;
         drive_d(vt[r].dv, vt[r].dsrc, 32'hD000_0000 | r, 1'b0, 1'b0);
         @(negedge clk);
         check($sformatf("row%0d m_a_ready", r), bus.m_a_ready, vt[r].e_mar);
         check($sformatf("row%0d tl_a_valid", r), bus.tl_a_valid, vt[r].e_av);
         if (vt[r].e_av) begin
            check($sformatf("row%0d tl_a_source", r), bus.tl_a_source, vt[r].e_asrc);
            check($sformatf("row%0d tl_a_address", r), bus.tl_a_address, vt[r].e_addr);
         end
         check($sformatf("row%0d m_d_valid", r), bus.m_d_valid, vt[r].e_dv);
         check($sformatf("row%0d tl_d_ready", r), bus.tl_d_ready, vt[r].e_dr);
         check($sformatf("row%0d err", r), err_unexpected, vt[r].e_err);
         if (vt[r].e_dv != '0) begin
            own = vt[r].e_dv[1] ? 1 : 0;
            check($sformatf("row%0d m_d_source", r), bus.m_d_source[own*SID +: SID], vt[r].e_dsrc);
            check($sformatf("row%0d m_d_data", r), bus.m_d_data[own*XLEN +: XLEN], 32'hD000_0000 | r);
         end
         next_cycle();
      end

      // Downstream stall: A stage must hold its fields while tl_a_ready is low.
      idle();
      put_r.op = 3'd0; put_r.param = 3'd0; put_r.size = 3'd2; put_r.src = 2'd3;
      put_r.addr = 32'h300; put_r.data = 32'hDEAD_BEEF; put_r.mask = 4'hF;
      drive_req(0, put_r);
      bus.m_a_valid = 2'b01;
      @(negedge clk);
      check("stall grant m0", bus.m_a_ready, 2'b01);
      next_cycle();
      drive_req(0, get_req(32'h999, 2'd0));
      bus.m_a_valid = 2'b11;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("stall%0d m_a_ready", c), bus.m_a_ready, 2'b00);
         check($sformatf("stall%0d tl_a_valid", c), bus.tl_a_valid, 1'b1);
         check($sformatf("stall%0d addr", c), bus.tl_a_address, 32'h300);
         check($sformatf("stall%0d data", c), bus.tl_a_data, 32'hDEAD_BEEF);
         check($sformatf("stall%0d misc", c),
               {bus.tl_a_opcode, bus.tl_a_source, bus.tl_a_mask}, {3'd0, 2'd0, 4'hF});
         next_cycle();
      end
      bus.tl_a_ready = 1'b1;
      @(negedge clk);
      check("stall release grant m1", bus.m_a_ready, 2'b10);
      check("stall release addr", bus.tl_a_address, 32'h300);
      next_cycle();
      idle();
      @(negedge clk);
      check("after stall tl_a_source", bus.tl_a_source, 2'd1);
      check("after stall addr", bus.tl_a_address, 32'h200);
      next_cycle();

      // Reset with two tags in flight and a loaded stage.
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("post-reset tl_a_valid", bus.tl_a_valid, 1'b0);
      check("post-reset m_a_ready", bus.m_a_ready, 2'b00);
      check("post-reset d outputs", {bus.m_d_valid, bus.tl_d_ready, err_unexpected}, 4'b0000);
      next_cycle();
      drive_d(1'b1, 2'd0, 32'h1234, 1'b0, 1'b0);
      bus.m_d_ready = 2'b11;
      @(negedge clk);
      check("stale tag err", err_unexpected, 1'b1);
      check("stale tag m_d_valid", bus.m_d_valid, 2'b00);
      check("stale tag tl_d_ready", bus.tl_d_ready, 1'b1);
      next_cycle();
      idle();
      drive_req(0, m0_req);
      bus.m_a_valid = 2'b11;
      bus.tl_a_ready = 1'b1;
      @(negedge clk);
      check("post-reset rr ptr", bus.m_a_ready, 2'b01);
      next_cycle();
      bus.m_a_valid = 2'b00;
      @(negedge clk);
      check("post-reset first tag", bus.tl_a_source, 2'd0);
      next_cycle();

      // Random traffic against the reference model.
      apply_reset();
      for (int i = 0; i < NM; i++) pend_v[i] = 1'b0;
      for (int t = 0; t < NTAGS; t++) tbusy[t] = 1'b0;
      stage_q.delete();
      down_q.delete();
      ptr = 0;
      begin
         bit             d_act = 1'b0;
         int             d_tag = 0;
         logic [XLEN-1:0] d_data = '0;
         logic [1:0]     d_flags = '0;
         for (int cyc = 0; cyc < 600; cyc++) begin
            int win, freet, exp_dr;
            bit do_grant;
            for (int i = 0; i < NM; i++) begin
               if (!pend_v[i] && $urandom_range(0, 99) < 60) begin
                  pend[i].op = 3'($urandom_range(0, 1) == 0 ? 4 : $urandom_range(0, 1));
                  pend[i].param = 3'd0;
                  pend[i].size = 3'd2;
                  pend[i].src = SID'($urandom);
                  pend[i].addr = $urandom;
                  pend[i].data = $urandom;
                  pend[i].mask = MSK'($urandom);
                  pend_v[i] = 1'b1;
               end
               bus.m_a_valid[i] = pend_v[i];
               drive_req(i, pend[i]);
            end
            bus.tl_a_ready = ($urandom_range(0, 99) < 70);
            bus.m_d_ready  = NM'($urandom);
            if (!d_act && down_q.size() > 0 && $urandom_range(0, 99) < 50) begin
               int k;
               k = $urandom_range(0, down_q.size() - 1);
               d_tag = down_q[k];
               down_q.delete(k);
               d_act = 1'b1;
               d_data = $urandom;
               d_flags = 2'($urandom);
            end else if (!d_act && $urandom_range(0, 99) < 5) begin
               for (int t = NTAGS - 1; t >= 0; t--) if (!tbusy[t]) begin d_tag = t; d_act = 1'b1; end
               d_data = $urandom;
               d_flags = 2'b00;
            end
            drive_d(d_act, SID'(d_tag), d_data, d_flags[1], d_flags[0]);
            @(negedge clk);

            win = -1;
            for (int k = 0; k < NM; k++) if (win < 0 && pend_v[(ptr + k) % NM]) win = (ptr + k) % NM;
            freet = -1;
            for (int t = 0; t < NTAGS; t++) if (freet < 0 && !tbusy[t]) freet = t;
            do_grant = (win >= 0) && (freet >= 0) && (stage_q.size() == 0 || bus.tl_a_ready);
            check($sformatf("rnd%0d m_a_ready", cyc), bus.m_a_ready, do_grant ? (1 << win) : 0);
            check($sformatf("rnd%0d tl_a_valid", cyc), bus.tl_a_valid, stage_q.size() > 0);
            if (stage_q.size() > 0) begin
               check($sformatf("rnd%0d tl_a_source", cyc), bus.tl_a_source, stage_q[0].tag);
               check($sformatf("rnd%0d tl_a_address", cyc), bus.tl_a_address, stage_q[0].r.addr);
               check($sformatf("rnd%0d tl_a_data", cyc), bus.tl_a_data, stage_q[0].r.data);
               check($sformatf("rnd%0d tl_a_misc", cyc),
                     {bus.tl_a_opcode, bus.tl_a_size, bus.tl_a_mask},
                     {stage_q[0].r.op, stage_q[0].r.size, stage_q[0].r.mask});
            end
            exp_dr = 0;
            if (d_act && tbusy[d_tag]) begin
               own = towner[d_tag];
               exp_dr = bus.m_d_ready[own];
               check($sformatf("rnd%0d m_d_valid", cyc), bus.m_d_valid, 1 << own);
               check($sformatf("rnd%0d tl_d_ready", cyc), bus.tl_d_ready, exp_dr);
               check($sformatf("rnd%0d m_d_source", cyc), bus.m_d_source[own*SID +: SID], tsrc[d_tag]);
               check($sformatf("rnd%0d m_d_data", cyc), bus.m_d_data[own*XLEN +: XLEN], d_data);
               check($sformatf("rnd%0d m_d_flags", cyc),
                     {bus.m_d_corrupt[own], bus.m_d_denied[own]}, d_flags);
               check($sformatf("rnd%0d err", cyc), err_unexpected, 1'b0);
            end else if (d_act) begin
               exp_dr = 1;
               check($sformatf("rnd%0d bogus err", cyc), err_unexpected, 1'b1);
               check($sformatf("rnd%0d bogus m_d_valid", cyc), bus.m_d_valid, 0);
               check($sformatf("rnd%0d bogus tl_d_ready", cyc), bus.tl_d_ready, 1'b1);
            end else begin
               check($sformatf("rnd%0d quiet d", cyc), {bus.m_d_valid, err_unexpected}, 0);
            end

            if (d_act && exp_dr != 0) begin
               tbusy[d_tag] = 1'b0;
               d_act = 1'b0;
            end
            if (stage_q.size() > 0 && bus.tl_a_ready) begin
               down_q.push_back(stage_q[0].tag);
               void'(stage_q.pop_front());
            end
            if (do_grant) begin
               tbusy[freet]  = 1'b1;
               towner[freet] = win;
               tsrc[freet]   = pend[win].src;
               stage_q.push_back('{r: pend[win], tag: freet});
               pend_v[win] = 1'b0;
               ptr = (win + 1) % NM;
            end
            next_cycle();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
